// File: rtl/race_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : race_pkg                                                       |
// | Purpose : Shared constants for the dice-race engine: FSM state codes     |
// |           and event_flag encodings.                                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package race_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_ROLL = 3'd1;
  localparam logic [2:0] S_MOVE      = 3'd2;
  localparam logic [2:0] S_EVENT     = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_WIN       = 3'd5;

  // event_flag encodings
  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_FWD  = 2'b01;
  localparam logic [1:0] EV_BACK = 2'b10;

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : step_timer                                                     |
// | Purpose : Animation pacing counter. Counts 0..STEP_TICKS-1 while enable  |
// |           is high and emits a one-cycle tick on the terminal count.      |
// | Ports   : clk, reset (sync, active-high), clear (restart at 0),          |
// |           enable (count), tick (terminal-count pulse, combinational)     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module step_timer #(
  parameter int STEP_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int c_cnt_w = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(STEP_TICKS - 1);

  logic [c_cnt_w-1:0] r_count;
  logic               w_term;

  assign w_term = (r_count == c_last);
  assign tick   = enable && !clear && w_term;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (w_term) r_count <= '0;
      else        r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/race_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : race_game_engine                                               |
// | Purpose : N-player dice-race engine. Accepts armed dice results, steps   |
// |           the current player square by square, applies event squares,    |
// |           handles exact-finish bounce-back, rotates turns, declares win. |
// | Ports   : clk, reset (sync, active-high), start, dice_valid, dice_value, |
// |           white_stable  -> inputs                                        |
// |           pos_flat, turn, turn_done, pos_valid, event_flag,              |
// |           winner_valid, winner_id, busy, steps_left -> outputs           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module race_game_engine
  import race_pkg::*;
#(
  parameter int                   NUM_PLAYERS = 2,
  parameter int                   BOARD_LEN   = 16,
  parameter int                   DICE_W      = 2,
  parameter int                   STEP_TICKS  = 12_500_000,
  parameter logic [BOARD_LEN-1:0] FWD_MASK    = 16'h0210,
  parameter logic [BOARD_LEN-1:0] BACK_MASK   = 16'h2000,
  parameter int                   EVENT_JUMP  = 2,
  parameter bit                   BOUNCE      = 1'b1,
  localparam int                  POS_W       = $clog2(BOARD_LEN),
  localparam int                  PID_W       = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         dice_valid,
  input  logic [DICE_W-1:0]            dice_value,
  input  logic                         white_stable,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
  output logic [PID_W-1:0]             turn,
  output logic                         turn_done,
  output logic                         pos_valid,
  output logic [1:0]                   event_flag,
  output logic                         winner_valid,
  output logic [PID_W-1:0]             winner_id,
  output logic                         busy,
  output logic [2:0]                   steps_left
);

  // One extra bit of headroom so +jump / -1 / -jump never wrap before clamping.
  localparam logic [POS_W:0]   c_goal     = (POS_W+1)'(BOARD_LEN - 1);
  localparam logic [POS_W:0]   c_jump     = (POS_W+1)'(EVENT_JUMP);
  localparam logic [PID_W-1:0] c_last_pid = PID_W'(NUM_PLAYERS - 1);

  logic [2:0]       r_state;
  logic [POS_W-1:0] r_pos [NUM_PLAYERS];
  logic [PID_W-1:0] r_turn;
  logic [PID_W-1:0] r_winner;
  logic             r_armed;
  logic             r_dir_back;
  logic [2:0]       r_steps;
  logic             r_pos_valid;
  logic             r_turn_done;
  logic [1:0]       r_event;

  logic [POS_W:0]   w_cur;
  logic [POS_W:0]   w_fwd;
  logic [POS_W:0]   w_step_pos;
  logic [POS_W:0]   w_jump_sum;
  logic [POS_W:0]   w_ev_fwd_pos;
  logic [POS_W:0]   w_ev_back_pos;
  logic             w_at_goal;
  logic             w_fwd_hit;
  logic             w_back_hit;
  logic             w_accept;
  logic             w_tick;

  assign w_cur         = {1'b0, r_pos[r_turn]};
  assign w_fwd         = w_cur + 1'b1;
  assign w_step_pos    = r_dir_back ? ((w_cur == '0) ? '0 : w_cur - 1'b1) : w_fwd;
  assign w_jump_sum    = w_cur + c_jump;
  assign w_ev_fwd_pos  = (w_jump_sum > c_goal) ? c_goal : w_jump_sum;
  assign w_ev_back_pos = (w_cur >= c_jump) ? (w_cur - c_jump) : '0;
  assign w_at_goal     = (w_cur == c_goal);
  // Event masks never apply on the goal square itself.
  assign w_fwd_hit     = !w_at_goal && FWD_MASK[r_pos[r_turn]];
  assign w_back_hit    = !w_at_goal && BACK_MASK[r_pos[r_turn]];
  assign w_accept      = (r_state == S_WAIT_ROLL) && dice_valid && r_armed;

  step_timer #(
    .STEP_TICKS (STEP_TICKS)
  ) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_accept),
    .enable (r_state == S_MOVE),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      for (int p = 0; p < NUM_PLAYERS; p++) r_pos[p] <= '0;
      r_turn      <= '0;
      r_winner    <= '0;
      r_armed     <= 1'b0;
      r_dir_back  <= 1'b0;
      r_steps     <= '0;
      r_pos_valid <= 1'b0;
      r_turn_done <= 1'b0;
      r_event     <= EV_NONE;
    end else begin
      r_pos_valid <= 1'b0;
      r_turn_done <= 1'b0;
      r_event     <= EV_NONE;
      case (r_state)
        S_IDLE, S_WIN: begin
          if (start) begin
            for (int p = 0; p < NUM_PLAYERS; p++) r_pos[p] <= '0;
            r_turn   <= '0;
            r_winner <= '0;
            r_armed  <= 1'b0;
            r_state  <= S_WAIT_ROLL;
          end
        end
        S_WAIT_ROLL: begin
          if (w_accept) begin
            r_steps    <= 3'(dice_value) + 3'd1;
            r_armed    <= 1'b0;
            r_dir_back <= 1'b0;
            r_state    <= S_MOVE;
          end else if (white_stable) begin
            r_armed <= 1'b1;
          end
        end
        S_MOVE: begin
          if (w_tick) begin
            r_pos[r_turn] <= w_step_pos[POS_W-1:0];
            r_pos_valid   <= (w_step_pos != w_cur);
            if (!r_dir_back && (w_fwd == c_goal) && !BOUNCE) begin
              // Clamp mode: landing on the goal ends the move outright.
              r_steps <= '0;
              r_state <= S_EVENT;
            end else begin
              r_steps <= r_steps - 1'b1;
              if (!r_dir_back && (w_fwd == c_goal)) r_dir_back <= 1'b1;
              if (r_steps == 3'd1) r_state <= S_EVENT;
            end
          end
        end
        S_EVENT: begin
          if (w_fwd_hit) begin
            r_pos[r_turn] <= w_ev_fwd_pos[POS_W-1:0];
            r_pos_valid   <= (w_ev_fwd_pos != w_cur);
            r_event       <= EV_FWD;
          end else if (w_back_hit) begin
            r_pos[r_turn] <= w_ev_back_pos[POS_W-1:0];
            r_pos_valid   <= (w_ev_back_pos != w_cur);
            r_event       <= EV_BACK;
          end
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_at_goal) begin
            r_winner <= r_turn;
            r_state  <= S_WIN;
          end else begin
            r_turn      <= (r_turn == c_last_pid) ? '0 : r_turn + 1'b1;
            r_turn_done <= 1'b1;
            r_armed     <= 1'b0;
            r_state     <= S_WAIT_ROLL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pos
    assign pos_flat[p*POS_W +: POS_W] = r_pos[p];
  end

  assign turn         = r_turn;
  assign turn_done    = r_turn_done;
  assign pos_valid    = r_pos_valid;
  assign event_flag   = r_event;
  assign winner_valid = (r_state == S_WIN);
  assign winner_id    = r_winner;
  assign busy         = (r_state == S_MOVE) || (r_state == S_EVENT) || (r_state == S_CHECK);
  assign steps_left   = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_race_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_race_game_engine                                            |
// | Purpose : Self-checking bench. Three engines share one stimulus stream:  |
// |           A = 2 players bounce, B = 2 players clamp, C = 3 players       |
// |           bounce. A transaction-level game model predicts each one.      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_race_game_engine;

  localparam int               GOAL = 15;
  localparam logic [15:0]      FWD  = 16'h0210;
  localparam logic [15:0]      BACK = 16'h2000;
  localparam int               TICKS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dice_valid = 1'b0;
  logic [1:0] dice_value = 2'd0;
  logic       white_stable = 1'b0;

  logic [7:0]  pf_a, pf_b;
  logic [11:0] pf_c;
  logic        tn_a, tn_b, wi_a, wi_b;
  logic [1:0]  tn_c, wi_c;
  logic        pv [3];
  logic        td [3];
  logic        wv [3];
  logic        bz [3];
  logic [1:0]  ef [3];
  logic [2:0]  sl [3];
  logic [31:0] pf [3];
  logic [2:0]  tn [3];
  logic [2:0]  wi [3];

  assign pf[0] = {24'd0, pf_a};
  assign pf[1] = {24'd0, pf_b};
  assign pf[2] = {20'd0, pf_c};
  assign tn[0] = {2'd0, tn_a};
  assign tn[1] = {2'd0, tn_b};
  assign tn[2] = {1'b0, tn_c};
  assign wi[0] = {2'd0, wi_a};
  assign wi[1] = {2'd0, wi_b};
  assign wi[2] = {1'b0, wi_c};

  always #5 clk = ~clk;

  race_game_engine #(.NUM_PLAYERS(2), .BOARD_LEN(16), .DICE_W(2), .STEP_TICKS(TICKS),
    .FWD_MASK(FWD), .BACK_MASK(BACK), .EVENT_JUMP(2), .BOUNCE(1'b1)) u_a (
    .clk(clk), .reset(reset), .start(start), .dice_valid(dice_valid), .dice_value(dice_value),
    .white_stable(white_stable), .pos_flat(pf_a), .turn(tn_a), .turn_done(td[0]),
    .pos_valid(pv[0]), .event_flag(ef[0]), .winner_valid(wv[0]), .winner_id(wi_a),
    .busy(bz[0]), .steps_left(sl[0]));

  race_game_engine #(.NUM_PLAYERS(2), .BOARD_LEN(16), .DICE_W(2), .STEP_TICKS(TICKS),
    .FWD_MASK(FWD), .BACK_MASK(BACK), .EVENT_JUMP(2), .BOUNCE(1'b0)) u_b (
    .clk(clk), .reset(reset), .start(start), .dice_valid(dice_valid), .dice_value(dice_value),
    .white_stable(white_stable), .pos_flat(pf_b), .turn(tn_b), .turn_done(td[1]),
    .pos_valid(pv[1]), .event_flag(ef[1]), .winner_valid(wv[1]), .winner_id(wi_b),
    .busy(bz[1]), .steps_left(sl[1]));

  race_game_engine #(.NUM_PLAYERS(3), .BOARD_LEN(16), .DICE_W(2), .STEP_TICKS(TICKS),
    .FWD_MASK(FWD), .BACK_MASK(BACK), .EVENT_JUMP(2), .BOUNCE(1'b1)) u_c (
    .clk(clk), .reset(reset), .start(start), .dice_valid(dice_valid), .dice_value(dice_value),
    .white_stable(white_stable), .pos_flat(pf_c), .turn(tn_c), .turn_done(td[2]),
    .pos_valid(pv[2]), .event_flag(ef[2]), .winner_valid(wv[2]), .winner_id(wi_c),
    .busy(bz[2]), .steps_left(sl[2]));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- output monitors ----------------
  int pvq [3][$];
  int nflag [3];
  int lastflag [3];
  int tdc [3];
  int first_pv [3];

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (pv[k]) begin
          pvq[k].push_back(int'(tn[k]) * 100 + int'(pf[k][int'(tn[k]) * 4 +: 4]));
          if (first_pv[k] < 0) first_pv[k] = cyc;
        end
        if (ef[k] != 2'b00) begin
          nflag[k]++;
          lastflag[k] = int'(ef[k]);
        end
        if (td[k]) tdc[k]++;
      end
    end
  end

  // ---------------- game model (transaction level) ----------------
  int mpos [3][8];
  int mturn [3];
  int mwid [3];
  bit mwon [3];
  bit mstart [3];
  bit marm [3];
  int np [3]  = '{2, 2, 3};
  bit bnc [3] = '{1'b1, 1'b0, 1'b1};
  int exp_pv [3][$];
  int exp_flag [3];
  int exp_td [3];

  task automatic clear_obs();
    for (int k = 0; k < 3; k++) begin
      pvq[k].delete();
      exp_pv[k].delete();
      nflag[k] = 0; lastflag[k] = 0; tdc[k] = 0; first_pv[k] = -1;
      exp_flag[k] = 0; exp_td[k] = 0;
    end
  endtask

  task automatic model_new_game(input int k);
    for (int p = 0; p < 8; p++) mpos[k][p] = 0;
    mturn[k] = 0; mwid[k] = 0; mwon[k] = 0; marm[k] = 0; mstart[k] = 1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      model_new_game(k);
      mstart[k] = 0;
    end
  endtask

  task automatic model_roll(input int k, input int d);
    int p, q, left;
    bit back;
    if (!mstart[k] || mwon[k] || !marm[k]) return;
    marm[k] = 0;
    p = mpos[k][mturn[k]];
    left = d + 1;
    back = 0;
    while (left > 0) begin
      q = back ? ((p > 0) ? p - 1 : 0) : p + 1;
      if (q != p) exp_pv[k].push_back(mturn[k] * 100 + q);
      left--;
      if (!back && q == GOAL) begin
        if (bnc[k]) back = 1;
        else left = 0;
      end
      p = q;
    end
    q = p;
    if (p != GOAL && FWD[p]) begin
      q = (p + 2 > GOAL) ? GOAL : p + 2;
      exp_flag[k] = 1;
    end else if (p != GOAL && BACK[p]) begin
      q = (p >= 2) ? p - 2 : 0;
      exp_flag[k] = 2;
    end
    if (q != p) exp_pv[k].push_back(mturn[k] * 100 + q);
    mpos[k][mturn[k]] = q;
    if (q == GOAL) begin
      mwon[k] = 1;
      mwid[k] = mturn[k];
    end else begin
      mturn[k] = (mturn[k] + 1) % np[k];
      exp_td[k] = 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    clear_obs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 3; k++) if (!mstart[k] || mwon[k]) model_new_game(k);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_roll(input bit w, input int d);
    clear_obs();
    if (w) begin
      @(posedge clk); #1 white_stable = 1'b1;
      @(posedge clk); #1 white_stable = 1'b0;
      for (int k = 0; k < 3; k++) if (mstart[k] && !mwon[k]) marm[k] = 1;
    end
    @(posedge clk); #1 dice_valid = 1'b1; dice_value = 2'(d);
    @(posedge clk); #1 dice_valid = 1'b0;
    t_acc = cyc;
    for (int k = 0; k < 3; k++) model_roll(k, d);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < np[k]; p++)
        chk($sformatf("%s dut%0d pos[%0d]", tag, k, p), int'(pf[k][p*4 +: 4]), mpos[k][p]);
      chk($sformatf("%s dut%0d turn", tag, k), int'(tn[k]), mturn[k]);
      chk($sformatf("%s dut%0d winner_valid", tag, k), int'(wv[k]), int'(mwon[k]));
      if (mwon[k]) chk($sformatf("%s dut%0d winner_id", tag, k), int'(wi[k]), mwid[k]);
      chk($sformatf("%s dut%0d busy", tag, k), int'(bz[k]), 0);
      chk($sformatf("%s dut%0d pos_valid count", tag, k), pvq[k].size(), exp_pv[k].size());
      for (int i = 0; i < pvq[k].size() && i < exp_pv[k].size(); i++)
        chk($sformatf("%s dut%0d pos_valid[%0d] player*100+pos", tag, k, i), pvq[k][i], exp_pv[k][i]);
      chk($sformatf("%s dut%0d event pulses", tag, k), nflag[k], (exp_flag[k] != 0) ? 1 : 0);
      if (exp_flag[k] != 0) chk($sformatf("%s dut%0d event_flag", tag, k), lastflag[k], exp_flag[k]);
      chk($sformatf("%s dut%0d turn_done pulses", tag, k), tdc[k], exp_td[k]);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s dut%0d pos_flat", tag, k), int'(pf[k]), 0);
      chk($sformatf("%s dut%0d turn", tag, k), int'(tn[k]), 0);
      chk($sformatf("%s dut%0d pulses", tag, k), int'({pv[k], td[k], ef[k]}), 0);
      chk($sformatf("%s dut%0d winner", tag, k), int'({wv[k], wi[k]}), 0);
      chk($sformatf("%s dut%0d busy", tag, k), int'(bz[k]), 0);
      chk($sformatf("%s dut%0d steps_left", tag, k), int'(sl[k]), 0);
    end
  endtask

  // Directed table for engine A (2 players, bounce): roll in, end state out.
  typedef struct {
    bit w;
    int d;
    int p0;
    int p1;
    int turn;
    int flag;
    int npv;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 3,  6, 0, 1, 1, 5};  // 1..4, forward event to 6
    tbl[1] = '{1'b0, 0,  6, 0, 1, 0, 0};  // not re-armed: ignored
    tbl[2] = '{1'b1, 0,  6, 1, 0, 0, 1};
    tbl[3] = '{1'b1, 3, 10, 1, 1, 0, 4};
    tbl[4] = '{1'b1, 3, 10, 5, 0, 0, 4};
    tbl[5] = '{1'b1, 3, 14, 5, 1, 0, 4};
    tbl[6] = '{1'b1, 0, 14, 6, 0, 0, 1};
    tbl[7] = '{1'b1, 2, 11, 6, 1, 2, 4};  // 15,14,13 bounce, back event to 11
    tbl[8] = '{1'b1, 1, 11, 8, 0, 0, 2};

    clear_obs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("power-on reset");
    reset = 1'b0;

    pulse_start();
    check_all("after start");

    for (int i = 0; i < 9; i++) begin
      do_roll(tbl[i].w, tbl[i].d);
      chk($sformatf("vec%0d A p0", i), int'(pf_a[3:0]), tbl[i].p0);
      chk($sformatf("vec%0d A p1", i), int'(pf_a[7:4]), tbl[i].p1);
      chk($sformatf("vec%0d A turn", i), int'(tn_a), tbl[i].turn);
      chk($sformatf("vec%0d A event_flag", i), lastflag[0], tbl[i].flag);
      chk($sformatf("vec%0d A pos_valid count", i), pvq[0].size(), tbl[i].npv);
      if (tbl[i].npv > 0)
        chk($sformatf("vec%0d A first-step latency", i), first_pv[0] - t_acc, TICKS);
      check_all($sformatf("vec%0d", i));
    end

    // Clamp engine won on vec7 with player 0; a restart clears it, others ignore start.
    chk("B won before restart", int'(wv[1]), 1);
    pulse_start();
    chk("B restart pos_flat", int'(pf_b), 0);
    chk("B restart turn", int'(tn_b), 0);
    chk("B restart winner_valid", int'(wv[1]), 0);
    check_all("restart");

    // Reset in the middle of a move.
    clear_obs();
    @(posedge clk); #1 white_stable = 1'b1;
    @(posedge clk); #1 white_stable = 1'b0;
    @(posedge clk); #1 dice_valid = 1'b1; dice_value = 2'd3;
    @(posedge clk); #1 dice_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (sl[0] != 3'd2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("reach steps_left==2", int'(sl[0]), 2);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check_reset("mid-move reset");
    reset = 1'b0;
    model_reset();
    pulse_start();
    do_roll(1'b1, 1);
    check_all("post-reset roll");

    // Randomised play against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        pulse_start();
        check_all($sformatf("rnd%0d start", i));
      end
      do_roll($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)));
      check_all($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
